// File: rtl/stock_pkg.sv
// Shared constants and types for the vending-machine stock register bank.
package stock_pkg;

    localparam int NUM_ITEMS = 7;
    localparam int CNT_W     = 3;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [2:0]       ITEM_NONE = 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        COMMIT,
        RESP
    } state_t;

    typedef struct packed {
        logic             supply;
        logic [2:0]       item;
        logic [CNT_W-1:0] qty;
    } req_t;

endpackage

// File: rtl/stock_alu.sv
// Combinational supply/sale rule for one stock counter: saturating restock,
// all-or-nothing sale.
module stock_alu
    import stock_pkg::*;
(
    input  logic             supply,
    input  logic [CNT_W-1:0] count,
    input  logic [CNT_W-1:0] qty,
    output logic [CNT_W-1:0] new_count,
    output logic [CNT_W-1:0] granted,
    output logic             ok
);

    // One extra bit keeps headroom and the compares free of wrap.
    logic [CNT_W:0] headroom;
    logic [CNT_W:0] qty_w;
    logic [CNT_W:0] cnt_w;

    assign headroom = {1'b0, CNT_MAX} - {1'b0, count};
    assign qty_w    = {1'b0, qty};
    assign cnt_w    = {1'b0, count};

    always_comb begin
        new_count = count;
        granted   = '0;
        ok        = 1'b0;
        if (supply) begin
            if (qty_w <= headroom) begin
                granted = qty;
                ok      = 1'b1;
            end else begin
                granted = headroom[CNT_W-1:0];
            end
            new_count = count + granted;
        end else if (qty_w <= cnt_w) begin
            new_count = count - qty;
            granted   = qty;
            ok        = 1'b1;
        end
    end

endmodule

// File: rtl/stock_keeper.sv
// Per-item stock register bank with a four-state request/response sequencer
// (accept, evaluate, commit, respond).
module stock_keeper
    import stock_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_supply,
    input  logic [2:0]           req_item,
    input  logic [CNT_W-1:0]     req_qty,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_ok,
    output logic [CNT_W-1:0]     resp_granted,
    output logic [CNT_W-1:0]     count1,
    output logic [CNT_W-1:0]     count2,
    output logic [CNT_W-1:0]     count3,
    output logic [CNT_W-1:0]     count4,
    output logic [CNT_W-1:0]     count5,
    output logic [CNT_W-1:0]     count6,
    output logic [CNT_W-1:0]     count7,
    output logic [NUM_ITEMS-1:0] sold_out
);

    state_t state, state_nxt;
    req_t   req_q;

    logic [NUM_ITEMS-1:0][CNT_W-1:0] cnt;
    logic [CNT_W-1:0]                pend_cnt;
    logic                            pend_we;

    logic             req_bad;
    logic [2:0]       idx;
    logic [CNT_W-1:0] cur_cnt;
    logic [CNT_W-1:0] alu_cnt;
    logic [CNT_W-1:0] alu_granted;
    logic             alu_ok;

    // Item 0 would index past the array; steer it to slot 0 and mask the write.
    assign req_bad = (req_q.item == ITEM_NONE) || (req_q.qty == '0);
    assign idx     = (req_q.item == ITEM_NONE) ? 3'd0 : req_q.item - 3'd1;
    assign cur_cnt = cnt[idx];

    stock_alu u_alu (
        .supply    (req_q.supply),
        .count     (cur_cnt),
        .qty       (req_q.qty),
        .new_count (alu_cnt),
        .granted   (alu_granted),
        .ok        (alu_ok)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = EVAL;
            end
            EVAL:   state_nxt = COMMIT;
            COMMIT: state_nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q        <= '0;
            resp_ok      <= 1'b0;
            resp_granted <= '0;
            pend_cnt     <= '0;
            pend_we      <= 1'b0;
            cnt          <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) req_q <= '{supply: req_supply, item: req_item, qty: req_qty};
                EVAL: begin
                    resp_ok      <= alu_ok & ~req_bad;
                    resp_granted <= req_bad ? '0 : alu_granted;
                    pend_cnt     <= alu_cnt;
                    pend_we      <= ~req_bad;
                end
                COMMIT: if (pend_we) cnt[idx] <= pend_cnt;
                default: ;
            endcase
        end
    end

    generate
        for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_sold
            assign sold_out[i] = (cnt[i] == '0);
        end
    endgenerate

    assign count1 = cnt[0];
    assign count2 = cnt[1];
    assign count3 = cnt[2];
    assign count4 = cnt[3];
    assign count5 = cnt[4];
    assign count6 = cnt[5];
    assign count7 = cnt[6];

endmodule
